mc_ctrl_fsm: RTL and testbench
==============================

Name: mc_ctrl_fsm

Overview:
- Multicycle RISC-V RV32I control unit: the issuing side of the ALU interface.
- Decodes the instruction register and sequences fetch/decode/execute/memory/writeback.
- Drives the ALU select code, operand muxes, write enables and the memory handshake.
- Consumes the ALU CMP flag for branch resolution; the datapath (PC, OLDPC, IR, ALUOUT, MDR, regfile) lives outside.

Parameters:
CNT_W, 32, width of retired-instruction counter RETIRED.

Ports:
CLK  in  1  clock
RESET  in  1  synchronous, active-high reset
INSTR  in  32  instruction register contents (valid from DECODE onward)
CMP  in  1  ALU compare result
MEM_READY  in  1  memory access completes this cycle
ALU_S  out  6  ALU operation code (shared ALU_* codes)
A_SEL  out  2  ALU A operand: 0=rs1, 1=PC, 2=OLDPC, 3=zero
B_SEL  out  2  ALU B operand: 0=rs2, 1=imm, 2=const 4
PC_WE  out  1  PC write enable
PC_SRC  out  2  PC source: 0=ALU Q, 1=OLDPC+imm adder, 2=ALU Q with bit0 cleared
IR_WE  out  1  latch INSTR and OLDPC<=PC
MEM_RE  out  1  memory read request
MEM_WE  out  1  memory write request
ADDR_SEL  out  1  memory address: 0=PC, 1=ALUOUT
MDR_WE  out  1  latch load data
RF_WE  out  1  register file write
WD_SEL  out  2  register write data: 0=ALUOUT, 1=MDR, 2=PC
ILLEGAL  out  1  sticky illegal-opcode flag
RETIRED  out  CNT_W  retired instruction count

Behaviour:
- Reset (synchronous, active-high):
  - Next state FETCH; ILLEGAL=0; RETIRED=0.
  - While RESET=1, all strobes, ALU_S and selects are forced to 0.
  - RESET asserted mid-access abandons the access with no write.
- Outputs are Moore: decoded from state plus INSTR. Only the BRANCH PC_WE depends combinationally on CMP.
- States: FETCH, DECODE, EXEC, MEM, WB, TRAP.
- FETCH:
  - MEM_RE=1, ADDR_SEL=0.
  - Hold while MEM_READY=0.
  - In the MEM_READY=1 cycle assert IR_WE, then go to DECODE.
- DECODE:
  - A_SEL=1, B_SEL=2, ALU_S=ALU_ADD, PC_WE=1, PC_SRC=0 (PC<=PC+4).
  - Unsupported opcode[6:0] -> TRAP (PC increment still occurs); otherwise -> EXEC.
- EXEC by opcode:
  - OP (0110011): A=rs1, B=rs2, ALU_S from funct3/funct7[5] (000 ADD/SUB, 001 SLL, 010 SLT, 011 SLTU, 100 XOR, 101 SRL/SRA, 110 OR, 111 AND) -> WB.
  - OP-IMM (0010011): same table, B=imm. funct7[5] is honoured only for funct3=101 (SRAI); ADDI never maps to SUB -> WB.
  - LOAD (0000011) / STORE (0100011): ALU_ADD, rs1+imm -> MEM.
  - BRANCH (1100011):
    - ALU_S from funct3: 000 EQ, 001 NE, 100 LT, 101 GE, 110 LTU, 111 GEU; A=rs1, B=rs2.
    - PC_WE=CMP, PC_SRC=1; -> FETCH.
    - funct3 010/011 -> TRAP.
  - JAL (1101111): RF_WE=1, WD_SEL=2, PC_WE=1, PC_SRC=1 -> FETCH.
  - JALR (1100111): ALU_ADD rs1+imm, PC_WE=1, PC_SRC=2, RF_WE=1, WD_SEL=2 -> FETCH. The rd write uses PC (already +4) before the PC update; both take effect on the same edge.
  - LUI (0110111): A=zero, B=imm, ALU_ADD -> WB.
  - AUIPC (0010111): A=OLDPC, B=imm, ALU_ADD -> WB.
- MEM:
  - ADDR_SEL=1. LOAD asserts MEM_RE, STORE asserts MEM_WE; hold until MEM_READY.
  - LOAD with ready: MDR_WE=1, -> WB.
  - STORE with ready: -> FETCH.
- WB: RF_WE=1, WD_SEL=1 for LOAD else 0; -> FETCH. rd=x0 suppression is the regfile's job.
- TRAP: ILLEGAL=1, all strobes 0, remains until RESET.
- RETIRED: increments (wrapping at 2^CNT_W) on every transition into FETCH from EXEC, MEM or WB. Trapped instructions never count.
- A memory request is held stable (address select, RE/WE) for every wait cycle; ready and request in the same cycle complete in one cycle.

Decomposition:
- Shared header:
  - ALU_* operation codes (already shared with the ALU).
  - OPC_* opcode constants.
  - State encoding.
  - A_SEL/B_SEL/PC_SRC/WD_SEL codes.
- One combinational sub-module: alu_op_decoder (opcode, funct3, funct7[5] -> ALU_S, legal flag).

Test Plan:
- RESET=1 for 2 cycles, MEM_READY=0 -> all strobes 0, then MEM_RE=1 ADDR_SEL=0 held; MEM_READY=1 on cycle 4 -> IR_WE pulse once, then DECODE.
- INSTR=0x40B50533 (sub a0,a0,a1), ready immediate -> EXEC ALU_S=ALU_SUB A_SEL=0 B_SEL=0, next cycle RF_WE=1 WD_SEL=0; RETIRED 0->1; 4 cycles total.
- INSTR=0x00B50463 (beq) with CMP=1 -> PC_WE=1 PC_SRC=1 in EXEC; with CMP=0 -> PC_WE=0 in EXEC; both return to FETCH.
- INSTR=0x00052503 (lw), MEM_READY low 3 cycles in MEM -> MEM_RE held 4 cycles, MDR_WE on ready cycle, WB WD_SEL=1.
- INSTR=0x00000000 -> TRAP after DECODE, ILLEGAL=1 stays and RETIRED unchanged; RESET clears ILLEGAL.
- INSTR=0x41F55513 (srai) -> ALU_SRA; 0x00F50513 (addi) -> ALU_ADD, not ALU_SUB.

Source files
------------

// File: rtl/mc_ctrl_fsm_pkg.sv
// Shared definitions for the multicycle RV32I control unit: ALU codes, opcodes,
// state encoding and the datapath mux select codes.
package mc_ctrl_fsm_pkg;

  // ALU operation codes, shared with the ALU
  localparam logic [5:0] ALU_ADD  = 6'd0;
  localparam logic [5:0] ALU_SUB  = 6'd1;
  localparam logic [5:0] ALU_SLL  = 6'd2;
  localparam logic [5:0] ALU_SLT  = 6'd3;
  localparam logic [5:0] ALU_SLTU = 6'd4;
  localparam logic [5:0] ALU_XOR  = 6'd5;
  localparam logic [5:0] ALU_SRL  = 6'd6;
  localparam logic [5:0] ALU_SRA  = 6'd7;
  localparam logic [5:0] ALU_OR   = 6'd8;
  localparam logic [5:0] ALU_AND  = 6'd9;
  localparam logic [5:0] ALU_EQ   = 6'd10;
  localparam logic [5:0] ALU_NE   = 6'd11;
  localparam logic [5:0] ALU_LT   = 6'd12;
  localparam logic [5:0] ALU_GE   = 6'd13;
  localparam logic [5:0] ALU_LTU  = 6'd14;
  localparam logic [5:0] ALU_GEU  = 6'd15;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

  typedef enum logic [2:0] {
    ST_FETCH, ST_DECODE, ST_EXEC, ST_MEM, ST_WB, ST_TRAP
  } state_t;

  localparam logic [1:0] A_RS1   = 2'd0;
  localparam logic [1:0] A_PC    = 2'd1;
  localparam logic [1:0] A_OLDPC = 2'd2;
  localparam logic [1:0] A_ZERO  = 2'd3;

  localparam logic [1:0] B_RS2  = 2'd0;
  localparam logic [1:0] B_IMM  = 2'd1;
  localparam logic [1:0] B_FOUR = 2'd2;

  localparam logic [1:0] PC_ALU      = 2'd0;
  localparam logic [1:0] PC_TGT      = 2'd1;
  localparam logic [1:0] PC_ALU_LSB0 = 2'd2;

  localparam logic [1:0] WD_ALU = 2'd0;
  localparam logic [1:0] WD_MDR = 2'd1;
  localparam logic [1:0] WD_PC  = 2'd2;

  // Opcode-level legality; funct3 checks happen later in EXEC
  function automatic logic opc_known(input logic [6:0] opc);
    return opc inside {OPC_OP, OPC_OPIMM, OPC_LOAD, OPC_STORE, OPC_BRANCH,
                       OPC_JAL, OPC_JALR, OPC_LUI, OPC_AUIPC};
  endfunction

endpackage

// File: rtl/mc_ctrl_fsm_if.sv
// Control/datapath bundle: instruction and status in, ALU/mux/strobe controls out.
interface mc_ctrl_fsm_if #(parameter int CNT_W = 32);
  logic [31:0]      instr;
  logic             cmp;
  logic             mem_ready;
  logic [5:0]       alu_s;
  logic [1:0]       a_sel;
  logic [1:0]       b_sel;
  logic             pc_we;
  logic [1:0]       pc_src;
  logic             ir_we;
  logic             mem_re;
  logic             mem_we;
  logic             addr_sel;
  logic             mdr_we;
  logic             rf_we;
  logic [1:0]       wd_sel;
  logic             illegal;
  logic [CNT_W-1:0] retired;

  modport master (
    input  instr, cmp, mem_ready,
    output alu_s, a_sel, b_sel, pc_we, pc_src, ir_we, mem_re, mem_we,
           addr_sel, mdr_we, rf_we, wd_sel, illegal, retired
  );

  modport slave (
    output instr, cmp, mem_ready,
    input  alu_s, a_sel, b_sel, pc_we, pc_src, ir_we, mem_re, mem_we,
           addr_sel, mdr_we, rf_we, wd_sel, illegal, retired
  );
endinterface

// File: rtl/mc_ctrl_fsm_alu_op_decoder.sv
// Maps opcode/funct3/funct7[5] to an ALU operation; flags unsupported encodings.
module alu_op_decoder
  import mc_ctrl_fsm_pkg::*;
(
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic       funct7_5,
  output logic [5:0] alu_s,
  output logic       legal
);

  always_comb begin
    alu_s = ALU_ADD;
    legal = 1'b1;
    case (opcode)
      OPC_OP, OPC_OPIMM: begin
        case (funct3)
          // the immediate form has no SUB; bit 30 there is just immediate data
          3'b000: alu_s = (opcode == OPC_OP && funct7_5) ? ALU_SUB : ALU_ADD;
          3'b001: alu_s = ALU_SLL;
          3'b010: alu_s = ALU_SLT;
          3'b011: alu_s = ALU_SLTU;
          3'b100: alu_s = ALU_XOR;
          3'b101: alu_s = funct7_5 ? ALU_SRA : ALU_SRL;
          3'b110: alu_s = ALU_OR;
          default: alu_s = ALU_AND;
        endcase
      end
      OPC_BRANCH: begin
        case (funct3)
          3'b000: alu_s = ALU_EQ;
          3'b001: alu_s = ALU_NE;
          3'b100: alu_s = ALU_LT;
          3'b101: alu_s = ALU_GE;
          3'b110: alu_s = ALU_LTU;
          3'b111: alu_s = ALU_GEU;
          default: legal = 1'b0;
        endcase
      end
      OPC_LOAD, OPC_STORE, OPC_JAL, OPC_JALR, OPC_LUI, OPC_AUIPC: ;
      default: legal = 1'b0;
    endcase
  end

endmodule

// File: rtl/mc_ctrl_fsm.sv
// Multicycle RV32I control FSM: FETCH/DECODE/EXEC/MEM/WB with a sticky TRAP state
// and a retired-instruction counter.
module mc_ctrl_fsm
  import mc_ctrl_fsm_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic          clk,
  input  logic          reset,
  mc_ctrl_fsm_if.master bus
);

  state_t           state, nxt;
  logic [CNT_W-1:0] retired;
  logic             retire;
  logic [6:0]       opcode;
  logic [2:0]       funct3;
  logic [5:0]       dec_alu;
  logic             dec_legal;
  logic             is_load;
  logic             unused_instr;

  assign opcode       = bus.instr[6:0];
  assign funct3       = bus.instr[14:12];
  assign is_load      = (opcode == OPC_LOAD);
  assign unused_instr = ^{bus.instr[31], bus.instr[29:15], bus.instr[11:7]};

  alu_op_decoder u_dec (
    .opcode   (opcode),
    .funct3   (funct3),
    .funct7_5 (bus.instr[30]),
    .alu_s    (dec_alu),
    .legal    (dec_legal)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= ST_FETCH;
      retired <= '0;
    end else begin
      state <= nxt;
      if (retire) retired <= retired + 1'b1;
    end
  end

  always_comb begin
    nxt          = state;
    bus.alu_s    = ALU_ADD;
    bus.a_sel    = A_RS1;
    bus.b_sel    = B_RS2;
    bus.pc_we    = 1'b0;
    bus.pc_src   = PC_ALU;
    bus.ir_we    = 1'b0;
    bus.mem_re   = 1'b0;
    bus.mem_we   = 1'b0;
    bus.addr_sel = 1'b0;
    bus.mdr_we   = 1'b0;
    bus.rf_we    = 1'b0;
    bus.wd_sel   = WD_ALU;
    if (reset) begin
      nxt = ST_FETCH;
    end else begin
      case (state)
        ST_FETCH: begin
          bus.mem_re = 1'b1;
          if (bus.mem_ready) begin
            bus.ir_we = 1'b1;
            nxt       = ST_DECODE;
          end
        end
        ST_DECODE: begin
          // PC <= PC + 4 unconditionally, even for an instruction about to trap
          bus.a_sel = A_PC;
          bus.b_sel = B_FOUR;
          bus.pc_we = 1'b1;
          nxt       = opc_known(opcode) ? ST_EXEC : ST_TRAP;
        end
        ST_EXEC: begin
          nxt = ST_WB;
          case (opcode)
            OPC_OP:    bus.alu_s = dec_alu;
            OPC_OPIMM: begin
              bus.alu_s = dec_alu;
              bus.b_sel = B_IMM;
            end
            OPC_LOAD, OPC_STORE: begin
              bus.b_sel = B_IMM;
              nxt       = ST_MEM;
            end
            OPC_BRANCH: begin
              if (dec_legal) begin
                bus.alu_s  = dec_alu;
                bus.pc_we  = bus.cmp;
                bus.pc_src = PC_TGT;
                nxt        = ST_FETCH;
              end else begin
                nxt = ST_TRAP;
              end
            end
            OPC_JAL: begin
              bus.rf_we  = 1'b1;
              bus.wd_sel = WD_PC;
              bus.pc_we  = 1'b1;
              bus.pc_src = PC_TGT;
              nxt        = ST_FETCH;
            end
            OPC_JALR: begin
              // rd gets the already-incremented PC on the same edge PC is redirected
              bus.b_sel  = B_IMM;
              bus.pc_we  = 1'b1;
              bus.pc_src = PC_ALU_LSB0;
              bus.rf_we  = 1'b1;
              bus.wd_sel = WD_PC;
              nxt        = ST_FETCH;
            end
            OPC_LUI: begin
              bus.a_sel = A_ZERO;
              bus.b_sel = B_IMM;
            end
            OPC_AUIPC: begin
              bus.a_sel = A_OLDPC;
              bus.b_sel = B_IMM;
            end
            default: nxt = ST_TRAP;
          endcase
        end
        ST_MEM: begin
          bus.addr_sel = 1'b1;
          bus.mem_re   = is_load;
          bus.mem_we   = !is_load;
          if (bus.mem_ready) begin
            bus.mdr_we = is_load;
            nxt        = is_load ? ST_WB : ST_FETCH;
          end
        end
        ST_WB: begin
          bus.rf_we  = 1'b1;
          bus.wd_sel = is_load ? WD_MDR : WD_ALU;
          nxt        = ST_FETCH;
        end
        ST_TRAP: nxt = ST_TRAP;
        default: nxt = ST_FETCH;
      endcase
    end
    retire = !reset && (nxt == ST_FETCH) && (state inside {ST_EXEC, ST_MEM, ST_WB});
  end

  assign bus.illegal = (state == ST_TRAP);
  assign bus.retired = retired;

endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// Cycle-by-cycle scoreboard bench for mc_ctrl_fsm: expected outputs are queued
// as each cycle's stimulus is applied and compared on the following negedge.
module tb_mc_ctrl_fsm;
  import mc_ctrl_fsm_pkg::*;

  typedef struct packed {
    logic [5:0] alu_s;
    logic [1:0] a_sel;
    logic [1:0] b_sel;
    logic       pc_we;
    logic [1:0] pc_src;
    logic       ir_we;
    logic       mem_re;
    logic       mem_we;
    logic       addr_sel;
    logic       mdr_we;
    logic       rf_we;
    logic [1:0] wd_sel;
    logic       illegal;
  } outv_t;

  typedef struct {
    string       tag;
    outv_t       o;
    logic [31:0] ret;
  } exp_t;

  localparam logic [31:0] I_SUB   = 32'h40B50533;
  localparam logic [31:0] I_BEQ   = 32'h00B50463;
  localparam logic [31:0] I_LW    = 32'h00052503;
  localparam logic [31:0] I_SW    = 32'h00B52023;
  localparam logic [31:0] I_SRAI  = 32'h41F55513;
  localparam logic [31:0] I_ADDI  = 32'h00F50513;
  localparam logic [31:0] I_ADDI2 = 32'h40F50513;
  localparam logic [31:0] I_LUI   = 32'h000012B7;
  localparam logic [31:0] I_JAL   = 32'h0000006F;
  localparam logic [31:0] I_BAD   = 32'h00000000;
  localparam logic [31:0] I_BBR   = 32'h00B52463;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   total = 0;
  int   bad = 0;
  exp_t q[$];
  outv_t obs_o;

  always #5 clk = ~clk;

  mc_ctrl_fsm_if #(.CNT_W(32)) bus ();
  mc_ctrl_fsm #(.CNT_W(32)) dut (.clk(clk), .reset(reset), .bus(bus.master));

  assign obs_o = {bus.alu_s, bus.a_sel, bus.b_sel, bus.pc_we, bus.pc_src, bus.ir_we,
                  bus.mem_re, bus.mem_we, bus.addr_sel, bus.mdr_we, bus.rf_we,
                  bus.wd_sel, bus.illegal};

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h", tag, obs, exp);
    end
  endtask

  function automatic outv_t e_idle();
    return '0;
  endfunction
  function automatic outv_t e_fetch(input logic rdy);
    outv_t o = '0;
    o.mem_re = 1'b1;
    o.ir_we  = rdy;
    return o;
  endfunction
  function automatic outv_t e_dec();
    outv_t o = '0;
    o.alu_s = ALU_ADD; o.a_sel = 2'd1; o.b_sel = 2'd2; o.pc_we = 1'b1; o.pc_src = 2'd0;
    return o;
  endfunction
  function automatic outv_t e_alu(input logic [5:0] op, input logic [1:0] a, input logic [1:0] b);
    outv_t o = '0;
    o.alu_s = op; o.a_sel = a; o.b_sel = b;
    return o;
  endfunction
  function automatic outv_t e_wb(input logic [1:0] wd);
    outv_t o = '0;
    o.rf_we = 1'b1; o.wd_sel = wd;
    return o;
  endfunction
  function automatic outv_t e_mem(input logic ld, input logic rdy);
    outv_t o = '0;
    o.addr_sel = 1'b1; o.mem_re = ld; o.mem_we = !ld; o.mdr_we = ld & rdy;
    return o;
  endfunction
  function automatic outv_t e_trap();
    outv_t o = '0;
    o.illegal = 1'b1;
    return o;
  endfunction

  // one clock: apply stimulus just after the edge, queue what this cycle should show
  task automatic cyc(input string tag, input logic r, input logic [31:0] ins, input logic c,
                     input logic rdy, input outv_t eo, input int eret);
    exp_t e;
    @(posedge clk);
    #1;
    reset = r; bus.instr = ins; bus.cmp = c; bus.mem_ready = rdy;
    e.tag = tag; e.o = eo; e.ret = 32'(eret);
    q.push_back(e);
  endtask

  task automatic fd(input string tag, input logic [31:0] ins, input int r);
    cyc({tag, ".f"}, 1'b0, ins, 1'b0, 1'b1, e_fetch(1'b1), r);
    cyc({tag, ".d"}, 1'b0, ins, 1'b0, 1'b0, e_dec(), r);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (q.size() > 0) begin
      e = q.pop_front();
      chk({e.tag, ".out"}, 64'(obs_o), 64'(e.o));
      chk({e.tag, ".ret"}, 64'(bus.retired), 64'(e.ret));
    end
  end

  initial begin
    int r;
    outv_t o;
    bus.instr = '0; bus.cmp = 1'b0; bus.mem_ready = 1'b0;
    r = 0;
    cyc("rst0", 1, I_SUB, 0, 0, e_idle(), 0);
    cyc("rst1", 1, I_SUB, 0, 1, e_idle(), 0);
    cyc("f_wait", 0, I_SUB, 0, 0, e_fetch(0), 0);
    cyc("f_rdy", 0, I_SUB, 0, 1, e_fetch(1), 0);
    cyc("sub.d", 0, I_SUB, 0, 0, e_dec(), 0);
    cyc("sub.x", 0, I_SUB, 0, 0, e_alu(ALU_SUB, 2'd0, 2'd0), 0);
    cyc("sub.w", 0, I_SUB, 0, 0, e_wb(2'd0), 0);
    r = 1;

    fd("beq1", I_BEQ, r);
    o = e_alu(ALU_EQ, 2'd0, 2'd0); o.pc_we = 1'b1; o.pc_src = 2'd1;
    cyc("beq1.x", 0, I_BEQ, 1, 0, o, r);
    r++;
    fd("beq0", I_BEQ, r);
    o.pc_we = 1'b0;
    cyc("beq0.x", 0, I_BEQ, 0, 0, o, r);
    r++;

    fd("lw", I_LW, r);
    cyc("lw.x", 0, I_LW, 0, 0, e_alu(ALU_ADD, 2'd0, 2'd1), r);
    for (int i = 0; i < 3; i++) cyc("lw.mwait", 0, I_LW, 0, 0, e_mem(1, 0), r);
    cyc("lw.mrdy", 0, I_LW, 0, 1, e_mem(1, 1), r);
    cyc("lw.w", 0, I_LW, 0, 0, e_wb(2'd1), r);
    r++;

    fd("srai", I_SRAI, r);
    cyc("srai.x", 0, I_SRAI, 0, 0, e_alu(ALU_SRA, 2'd0, 2'd1), r);
    cyc("srai.w", 0, I_SRAI, 0, 0, e_wb(2'd0), r);
    r++;
    fd("addi", I_ADDI, r);
    cyc("addi.x", 0, I_ADDI, 0, 0, e_alu(ALU_ADD, 2'd0, 2'd1), r);
    cyc("addi.w", 0, I_ADDI, 0, 0, e_wb(2'd0), r);
    r++;
    fd("addi2", I_ADDI2, r);
    cyc("addi2.x", 0, I_ADDI2, 0, 0, e_alu(ALU_ADD, 2'd0, 2'd1), r);
    cyc("addi2.w", 0, I_ADDI2, 0, 0, e_wb(2'd0), r);
    r++;
    fd("lui", I_LUI, r);
    cyc("lui.x", 0, I_LUI, 0, 0, e_alu(ALU_ADD, 2'd3, 2'd1), r);
    cyc("lui.w", 0, I_LUI, 0, 0, e_wb(2'd0), r);
    r++;

    fd("jal", I_JAL, r);
    o = e_wb(2'd2); o.pc_we = 1'b1; o.pc_src = 2'd1;
    cyc("jal.x", 0, I_JAL, 0, 0, o, r);
    r++;

    fd("sw", I_SW, r);
    cyc("sw.x", 0, I_SW, 0, 0, e_alu(ALU_ADD, 2'd0, 2'd1), r);
    cyc("sw.mwait", 0, I_SW, 0, 0, e_mem(0, 0), r);
    cyc("sw.mrdy", 0, I_SW, 0, 1, e_mem(0, 1), r);
    r++;

    // reset lands while a store is waiting: request drops, nothing retires
    fd("swrst", I_SW, r);
    cyc("swrst.x", 0, I_SW, 0, 0, e_alu(ALU_ADD, 2'd0, 2'd1), r);
    cyc("swrst.mwait", 0, I_SW, 0, 0, e_mem(0, 0), r);
    cyc("swrst.rst", 1, I_SW, 0, 1, e_idle(), r);
    r = 0;
    cyc("swrst.f", 0, I_SW, 0, 0, e_fetch(0), r);

    fd("sub2", I_SUB, r);
    cyc("sub2.x", 0, I_SUB, 0, 0, e_alu(ALU_SUB, 2'd0, 2'd0), r);
    cyc("sub2.w", 0, I_SUB, 0, 0, e_wb(2'd0), r);
    r++;

    fd("ill", I_BAD, r);
    cyc("ill.t0", 0, I_BAD, 0, 1, e_trap(), r);
    cyc("ill.t1", 0, I_BAD, 1, 1, e_trap(), r);
    cyc("ill.rst", 1, I_BAD, 0, 0, e_trap(), r);
    r = 0;
    cyc("ill.f", 0, I_BAD, 0, 0, e_fetch(0), r);

    fd("bbr", I_BBR, r);
    cyc("bbr.x", 0, I_BBR, 1, 0, e_idle(), r);
    cyc("bbr.t", 0, I_BBR, 1, 0, e_trap(), r);
    cyc("bbr.rst", 1, I_BBR, 0, 0, e_trap(), r);
    cyc("bbr.f", 0, I_BBR, 0, 0, e_fetch(0), r);

    @(negedge clk);
    #1;
    chk("q_drain", 64'(q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
